smc_qbus_master: RTL

Q-bus initiator that drives the stepper-motor controller's register interface (QSEL/QWRITE/QADDR/QDATAIN/QDATAOUT) from a host-side command stream.
- Accepts read/write commands over a valid/ready interface and buffers them in a small FIFO.
- Sequences one bus access at a time and returns one response per command (ack, read data, or address error).
- Sits between the CPU/sequencer fabric and the smc register block.

---
 rtl/smc_pkg.sv | 55 +++++
 rtl/smc_cmd_fifo.sv | 75 +++++++
 rtl/smc_qbus_master.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/smc_pkg.sv
// Shared definitions for the smc Q-bus initiator: register map, command
// record, sequencer states and the address decode helper.
package smc_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  // Control and period registers
  localparam logic [ADDR_W-1:0] MCCTL0_ADDR = 7'h00;
  localparam logic [ADDR_W-1:0] MCCTL1_ADDR = 7'h01;
  localparam logic [ADDR_W-1:0] MCPER_ADDR  = 7'h02;

  // Per-channel register banks: MCCCn at MCCC_BASE+n, MCDCn at MCDC_BASE+n
  localparam int                NUM_CH    = 12;
  localparam logic [ADDR_W-1:0] MCCC_BASE = 7'h10;
  localparam logic [ADDR_W-1:0] MCDC_BASE = 7'h20;
  localparam logic [ADDR_W-1:0] MCCC_LAST = MCCC_BASE + 7'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] MCDC_LAST = MCDC_BASE + 7'(NUM_CH - 1);

  // Channel register addresses, for callers that address a bank by index
  function automatic logic [ADDR_W-1:0] mccc_addr(input logic [3:0] ch);
    return MCCC_BASE + 7'(ch);
  endfunction

  function automatic logic [ADDR_W-1:0] mcdc_addr(input logic [3:0] ch);
    return MCDC_BASE + 7'(ch);
  endfunction

  // One host command as held in the command FIFO
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } smc_cmd_t;

  // Bus sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } smc_state_t;

  // True when the address hits a register that exists in the smc block
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    logic ctl_hit;
    logic cc_hit;
    logic dc_hit;
    ctl_hit = (addr <= MCPER_ADDR);
    cc_hit  = (addr >= MCCC_BASE) && (addr <= MCCC_LAST);
    dc_hit  = (addr >= MCDC_BASE) && (addr <= MCDC_LAST);
    return ctl_hit || cc_hit || dc_hit;
  endfunction

endpackage

// File: rtl/smc_cmd_fifo.sv
// Small show-ahead command FIFO. The head entry is visible combinationally
// so the sequencer can decode and pop it in the same IDLE cycle. in_ready is
// a registered copy of !full so the host-facing handshake has no logic path
// back from the pop side.
module smc_cmd_fifo
  import smc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       QCLK,
  input  logic                       QRESET,
  input  logic                       push,
  input  smc_cmd_t                   push_cmd,
  input  logic                       pop,
  output smc_cmd_t                   head_cmd,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       in_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  smc_cmd_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              in_ready_reg;

  assign head_cmd = mem[rd_ptr_reg];
  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign in_ready = in_ready_reg;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, occupancy and the registered ready flag
  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg    <= count_next;
      in_ready_reg <= (count_next != FULL_COUNT);
    end
  end

  // Storage array; contents need no reset because the pointers gate reads
  always_ff @(posedge QCLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_cmd;
    end
  end

endmodule

// File: rtl/smc_qbus_master.sv
// Q-bus initiator for the stepper-motor controller register block. Host
// commands are queued in a FIFO; the sequencer performs one single-cycle
// QSEL access at a time and returns exactly one response per command, in
// command order. Addresses outside the register map are answered with an
// error response and never reach the bus.
module smc_qbus_master
  import smc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,  // power of two, at least 2
  parameter int READ_LATENCY = 1   // 1..3 cycles from QSEL to valid QDATAOUT
) (
  input  logic        QCLK,
  input  logic        QRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        QSEL,
  output logic        QWRITE,
  output logic [6:0]  QADDR,
  output logic [15:0] QDATAIN,
  input  logic [15:0] QDATAOUT
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  smc_cmd_t          push_cmd;
  smc_cmd_t          head_cmd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_ready;

  smc_state_t        state_reg;
  logic [1:0]        wait_cnt_reg;
  logic              cur_write_reg;

  logic              qsel_reg;
  logic              qwrite_reg;
  logic [6:0]        qaddr_reg;
  logic [15:0]       qdatain_reg;

  logic              rsp_valid_reg;
  logic              rsp_write_reg;
  logic              rsp_err_reg;
  logic [15:0]       rsp_rdata_reg;

  assign push_cmd.write = cmd_write;
  assign push_cmd.addr  = cmd_addr;
  assign push_cmd.wdata = cmd_wdata;

  // The full check is redundant with the registered ready but keeps an
  // overflow impossible even if the two ever drift apart.
  assign cmd_ready = fifo_ready;
  assign fifo_push = cmd_valid && fifo_ready && !fifo_full;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

  smc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .QCLK     (QCLK),
    .QRESET   (QRESET),
    .push     (fifo_push),
    .push_cmd (push_cmd),
    .pop      (fifo_pop),
    .head_cmd (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .in_ready (fifo_ready)
  );

  assign busy = (fifo_count != '0) || (state_reg != IDLE);

  assign QSEL      = qsel_reg;
  assign QWRITE    = qwrite_reg;
  assign QADDR     = qaddr_reg;
  assign QDATAIN   = qdatain_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  // Bus sequencer: pop, decode, drive one QSEL cycle, collect read data,
  // then hold the response until the host takes it.
  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      cur_write_reg <= 1'b0;
      qsel_reg      <= 1'b0;
      qwrite_reg    <= 1'b0;
      qaddr_reg     <= '0;
      qdatain_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            if (!addr_valid(head_cmd.addr)) begin
              // Unmapped address: answer immediately, bus stays quiet
              rsp_valid_reg <= 1'b1;
              rsp_write_reg <= head_cmd.write;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= RESP;
            end else begin
              qsel_reg      <= 1'b1;
              qwrite_reg    <= head_cmd.write;
              qaddr_reg     <= head_cmd.addr;
              qdatain_reg   <= head_cmd.write ? head_cmd.wdata : 16'h0000;
              cur_write_reg <= head_cmd.write;
              state_reg     <= ACCESS;
            end
          end
        end

        ACCESS: begin
          // QSEL is a single-cycle strobe; return every bus net to zero
          qsel_reg    <= 1'b0;
          qwrite_reg  <= 1'b0;
          qaddr_reg   <= '0;
          qdatain_reg <= '0;
          if (cur_write_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_write_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg <= WAIT_LOAD;
            state_reg    <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          // The last counted cycle is the one in which QDATAOUT is valid
          if (wait_cnt_reg == 2'd0) begin
            rsp_valid_reg <= 1'b1;
            rsp_write_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= QDATAOUT;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
